// File: rtl/if_id_stage_pkg.sv
// Shared constants for the IF->ID pipeline stage.
// Widths, reset/bubble defaults and active levels of flush and reset.
package if_id_stage_pkg;

  localparam int InstAddrBus = 32;
  localparam int InstBus     = 32;

  localparam logic [31:0] RstAddr = 32'h0000_0000;
  localparam logic [31:0] NopInst = 32'h0000_0013;

  localparam logic FlushEn = 1'b1;
  localparam logic RstEn   = 1'b1;

endpackage

// File: rtl/if_id_stage_pipe_entry.sv
// One pipeline entry: valid bit plus address and instruction.
// Ports: flush_i (kill, restore defaults) > load_i (capture) > clr_i (drop valid).
module pipe_entry
  import if_id_stage_pkg::*;
#(
  parameter int                ADDR_W     = InstAddrBus,
  parameter int                INST_W     = InstBus,
  parameter logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(RstAddr),
  parameter logic [INST_W-1:0] NOP_INST   = INST_W'(NopInst)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              load_i,
  input  logic              clr_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [INST_W-1:0] inst_i,
  output logic              valid_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [INST_W-1:0] inst_o
);

  logic              valid_d, valid_q;
  logic [ADDR_W-1:0] addr_d, addr_q;
  logic [INST_W-1:0] inst_d, inst_q;

  // Clearing only drops valid so the address holds while draining.
  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    inst_d  = inst_q;
    if (flush_i == FlushEn) begin
      valid_d = 1'b0;
      addr_d  = RESET_ADDR;
      inst_d  = NOP_INST;
    end else if (load_i) begin
      valid_d = 1'b1;
      addr_d  = addr_i;
      inst_d  = inst_i;
    end else if (clr_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i == RstEn) begin
      valid_q <= 1'b0;
      addr_q  <= RESET_ADDR;
      inst_q  <= NOP_INST;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
      inst_q  <= inst_d;
    end
  end

  assign valid_o = valid_q;
  assign addr_o  = addr_q;
  assign inst_o  = inst_q;

endmodule

// File: rtl/if_id_stage.sv
// IF->ID stage with valid/ready on both sides, optional skid entry and flush.
// Ports: fetch side valid_i/ready_o/inst_*_i, decode side valid_o/ready_i/inst_*_o.
module if_id_stage
  import if_id_stage_pkg::*;
#(
  parameter int                ADDR_W     = InstAddrBus,
  parameter int                INST_W     = InstBus,
  parameter logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(RstAddr),
  parameter logic [INST_W-1:0] NOP_INST   = INST_W'(NopInst),
  parameter bit                SKID_EN    = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [ADDR_W-1:0] inst_addr_i,
  input  logic [INST_W-1:0] inst_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [ADDR_W-1:0] inst_addr_o,
  output logic [INST_W-1:0] inst_o,
  output logic              skid_full_o
);

  logic              m_valid, s_valid;
  logic [ADDR_W-1:0] m_addr, s_addr, m_addr_d;
  logic [INST_W-1:0] m_inst, s_inst, m_inst_d;
  logic              up, take_s;
  logic              m_load, m_clr, s_load;

  // Flush priority lives inside pipe_entry, so an upstream
  // transfer coinciding with flush is simply overridden.
  always_comb begin
    up       = valid_i & ready_o;
    take_s   = s_valid & ready_i;
    m_load   = take_s | (up & (~m_valid | ready_i));
    m_clr    = m_valid & ready_i;
    s_load   = up & m_valid & ~ready_i;
    m_addr_d = take_s ? s_addr : inst_addr_i;
    m_inst_d = take_s ? s_inst : inst_i;
  end

  pipe_entry #(
    .ADDR_W    (ADDR_W),
    .INST_W    (INST_W),
    .RESET_ADDR(RESET_ADDR),
    .NOP_INST  (NOP_INST)
  ) u_m (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .flush_i(flush_i),
    .load_i (m_load),
    .clr_i  (m_clr),
    .addr_i (m_addr_d),
    .inst_i (m_inst_d),
    .valid_o(m_valid),
    .addr_o (m_addr),
    .inst_o (m_inst)
  );

  generate
    if (SKID_EN) begin : g_skid
      pipe_entry #(
        .ADDR_W    (ADDR_W),
        .INST_W    (INST_W),
        .RESET_ADDR(RESET_ADDR),
        .NOP_INST  (NOP_INST)
      ) u_s (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .flush_i(flush_i),
        .load_i (s_load),
        .clr_i  (take_s),
        .addr_i (inst_addr_i),
        .inst_i (inst_i),
        .valid_o(s_valid),
        .addr_o (s_addr),
        .inst_o (s_inst)
      );
      // Registered: depends only on the skid flop.
      assign ready_o = ~s_valid;
    end else begin : g_noskid
      assign s_valid = 1'b0;
      assign s_addr  = '0;
      assign s_inst  = '0;
      assign ready_o = ready_i | ~m_valid;
    end
  endgenerate

  assign valid_o     = m_valid;
  assign inst_addr_o = m_addr;
  assign inst_o      = m_valid ? m_inst : NOP_INST;
  assign skid_full_o = s_valid;

endmodule

// File: tb/tb_if_id_stage.sv
// Scoreboard bench for if_id_stage (skid and non-skid builds).
// Directed handshake scenarios plus a random valid/ready/flush run.
module tb_if_id_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        vin = 1'b0;
  logic        rdy_in = 1'b0;
  logic [31:0] ain = '0;
  logic [31:0] iin = '0;
  logic        rdy_o, vout, skf;
  logic [31:0] aout, iout;

  logic        z_vin = 1'b0;
  logic        z_rdy_in = 1'b0;
  logic [31:0] z_ain = '0;
  logic [31:0] z_iin = '0;
  logic        z_rdy_o, z_vout, z_skf;
  logic [31:0] z_aout, z_iout;

  int pass_cnt = 0;
  int total_cnt = 0;
  bit mon_en = 1'b0;
  logic [63:0] q[$];

  always #5 clk = ~clk;

  if_id_stage #(.SKID_EN(1'b1)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .flush_i    (flush),
    .valid_i    (vin),
    .ready_o    (rdy_o),
    .inst_addr_i(ain),
    .inst_i     (iin),
    .valid_o    (vout),
    .ready_i    (rdy_in),
    .inst_addr_o(aout),
    .inst_o     (iout),
    .skid_full_o(skf)
  );

  if_id_stage #(.SKID_EN(1'b0)) dut0 (
    .clk_i      (clk),
    .rst_i      (rst),
    .flush_i    (1'b0),
    .valid_i    (z_vin),
    .ready_o    (z_rdy_o),
    .inst_addr_i(z_ain),
    .inst_i     (z_iin),
    .valid_o    (z_vout),
    .ready_i    (z_rdy_in),
    .inst_addr_o(z_aout),
    .inst_o     (z_iout),
    .skid_full_o(z_skf)
  );

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endfunction

  function automatic logic [31:0] mk(logic [31:0] a);
    return 32'hA000_0000 | a;
  endfunction

  // Expected-entry capture on every accepted, non-flushed input.
  always @(posedge clk) begin
    if (rst || flush) q.delete();
    else if (vin && rdy_o) q.push_back({ain, iin});
  end

  // Output monitor: held count drives expected handshake flags.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("valid_o", {31'd0, vout}, {31'd0, q.size() != 0});
      chk("ready_o", {31'd0, rdy_o}, {31'd0, q.size() < 2});
      chk("skid_full", {31'd0, skf}, {31'd0, q.size() == 2});
      if (vout) begin
        if (q.size() == 0) begin
          chk("dup_or_dropped_flush", aout, 32'hFFFF_FFFF);
        end else begin
          chk("addr_o", aout, q[0][63:32]);
          chk("inst_o", iout, q[0][31:0]);
          if (rdy_in) void'(q.pop_front());
        end
      end else begin
        chk("bubble_nop", iout, NOP);
      end
    end
  end

  task automatic step(bit v, logic [31:0] a, bit r, bit f);
    @(posedge clk);
    #1;
    vin = v;
    ain = a;
    iin = mk(a);
    rdy_in = r;
    flush = f;
  endtask

  initial begin
    #2;
    chk("rst_valid", {31'd0, vout}, 32'd0);
    chk("rst_inst", iout, NOP);
    chk("rst_addr", aout, 32'd0);
    chk("rst_ready", {31'd0, rdy_o}, 32'd1);
    chk("rst_skid", {31'd0, skf}, 32'd0);
    chk("rst_ready0", {31'd0, z_rdy_o}, 32'd1);
    chk("rst_skid0", {31'd0, z_skf}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    mon_en = 1'b1;

    // Streaming
    step(1, 32'h0, 1, 0);
    step(1, 32'h4, 1, 0);
    step(1, 32'h8, 1, 0);
    step(0, 32'h0, 1, 0);
    step(0, 32'h0, 1, 0);
    chk("drain_valid", {31'd0, vout}, 32'd0);
    chk("drain_hold_addr", aout, 32'h8);

    // Back-pressure into skid
    step(1, 32'h10, 0, 0);
    step(1, 32'h14, 0, 0);
    step(1, 32'h18, 0, 0);
    chk("bp_skid", {31'd0, skf}, 32'd1);
    chk("bp_ready", {31'd0, rdy_o}, 32'd0);
    chk("bp_head", aout, 32'h10);
    step(1, 32'h18, 0, 0);
    step(1, 32'h18, 1, 0);
    step(1, 32'h18, 1, 0);
    chk("bp_order", aout, 32'h14);
    step(0, 32'h0, 1, 0);
    step(0, 32'h0, 1, 0);
    step(0, 32'h0, 1, 0);

    // Flush in skid state with a simultaneous push
    step(1, 32'h20, 0, 0);
    step(1, 32'h24, 0, 0);
    step(1, 32'h28, 0, 1);
    step(0, 32'h0, 1, 0);
    chk("fl_valid", {31'd0, vout}, 32'd0);
    chk("fl_inst", iout, NOP);
    chk("fl_addr", aout, 32'd0);
    // Flush while ready_o=1: input dropped
    step(1, 32'h30, 0, 0);
    step(1, 32'h34, 0, 1);
    chk("fl_ready_hi", {31'd0, rdy_o}, 32'd1);
    step(0, 32'h0, 1, 0);
    chk("fl2_valid", {31'd0, vout}, 32'd0);
    chk("fl2_addr", aout, 32'd0);
    step(0, 32'h0, 1, 0);

    // Asynchronous reset mid-stream
    step(1, 32'h100, 0, 0);
    step(0, 32'h0, 0, 0);
    chk("pre_rst_addr", aout, 32'h100);
    mon_en = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", {31'd0, vout}, 32'd0);
    chk("arst_inst", iout, NOP);
    chk("arst_addr", aout, 32'd0);
    q.delete();
    step(0, 32'h0, 1, 0);
    rst = 1'b0;
    mon_en = 1'b1;

    // Single-entry build
    @(posedge clk);
    #1;
    z_vin = 1'b1;
    z_ain = 32'h40;
    z_iin = mk(32'h40);
    z_rdy_in = 1'b0;
    @(posedge clk);
    #1;
    z_vin = 1'b0;
    chk("z_valid", {31'd0, z_vout}, 32'd1);
    chk("z_ready_lo", {31'd0, z_rdy_o}, 32'd0);
    chk("z_addr40", z_aout, 32'h40);
    z_rdy_in = 1'b1;
    #1;
    chk("z_ready_comb", {31'd0, z_rdy_o}, 32'd1);
    z_vin = 1'b1;
    z_ain = 32'h44;
    z_iin = mk(32'h44);
    @(posedge clk);
    #1;
    chk("z_addr44", z_aout, 32'h44);
    chk("z_valid44", {31'd0, z_vout}, 32'd1);
    z_ain = 32'h48;
    z_iin = mk(32'h48);
    @(posedge clk);
    #1;
    chk("z_addr48", z_aout, 32'h48);
    chk("z_inst48", z_iout, 32'hA000_0048);
    z_vin = 1'b0;
    @(posedge clk);
    #1;
    chk("z_drain_valid", {31'd0, z_vout}, 32'd0);
    chk("z_drain_nop", z_iout, NOP);
    chk("z_drain_addr", z_aout, 32'h48);
    chk("z_skid0", {31'd0, z_skf}, 32'd0);

    // Random traffic
    for (int i = 0; i < 10000; i++) begin
      step($urandom_range(0, 9) < 7, 32'h1000 + 32'(i) * 4,
           $urandom_range(0, 9) < 6, $urandom_range(0, 99) < 3);
    end
    for (int i = 0; i < 5; i++) step(0, 32'h0, 1, 0);
    chk("no_drop", 32'(q.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
